// File: rtl/stream_merger_p.sv
// stream_merger_p: two-way merge of sorted, terminator-delimited runs.
// Each channel lands in a small circular FWFT buffer. The output register
// takes one decision per cycle, and only when both buffer heads are present.

// Circular input buffer with combinational head read. The pointers carry
// an extra wrap bit so that full and empty stay distinct across wrap.
module stream_merger_p_buf #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_head  = r_mem[r_rp[AW-1:0]];

    // Pointer update; a push into a full buffer is legal only alongside a pop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + ONE;
            if (i_pop)  r_rp <= r_rp + ONE;
        end
    end

    // Storage; the head was already read this cycle, so overwrite-on-pop is safe
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end
endmodule

module stream_merger_p #(
    parameter int           W       = 32,
    parameter int           DEPTH   = 4,
    parameter bit           DESCEND = 1'b0,
    parameter logic [W-1:0] TERM    = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_fifo_1,
    input  logic         i_fifo_1_empty,
    output logic         o_fifo_1_read,
    input  logic [W-1:0] i_fifo_2,
    input  logic         i_fifo_2_empty,
    output logic         o_fifo_2_read,
    input  logic         i_fifo_out_ready,
    output logic         o_out_fifo_write,
    output logic [W-1:0] o_data,
    output logic [15:0]  o_run_count,
    output logic         o_busy
);
    logic [W-1:0] w_a_head, w_b_head;
    logic         w_a_empty, w_b_empty, w_a_full, w_b_full;
    logic         w_adv, w_pop_a, w_pop_b, w_run_done;
    logic [W-1:0] w_nxt;
    logic [W-1:0] r_or;
    logic         r_ov;
    logic [15:0]  r_run_count;

    // Fetch whenever there is room, or room appears through this cycle's pop
    assign o_fifo_1_read = ~i_rst & ~i_fifo_1_empty & (~w_a_full | w_pop_a);
    assign o_fifo_2_read = ~i_rst & ~i_fifo_2_empty & (~w_b_full | w_pop_b);

    stream_merger_p_buf #(.W(W), .DEPTH(DEPTH)) u_buf_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(o_fifo_1_read), .i_data(i_fifo_1),
        .i_pop(w_pop_a), .o_head(w_a_head), .o_empty(w_a_empty), .o_full(w_a_full)
    );

    stream_merger_p_buf #(.W(W), .DEPTH(DEPTH)) u_buf_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(o_fifo_2_read), .i_data(i_fifo_2),
        .i_pop(w_pop_b), .o_head(w_b_head), .o_empty(w_b_empty), .o_full(w_b_full)
    );

    // Merge decision: a lone terminator waits for its partner; ties favour A
    always_comb begin
        w_adv      = ~w_a_empty & ~w_b_empty & (~r_ov | i_fifo_out_ready);
        w_pop_a    = 1'b0;
        w_pop_b    = 1'b0;
        w_run_done = 1'b0;
        w_nxt      = w_a_head;
        if (w_adv) begin
            if ((w_a_head == TERM) && (w_b_head == TERM)) begin
                w_pop_a    = 1'b1;
                w_pop_b    = 1'b1;
                w_run_done = 1'b1;
                w_nxt      = TERM;
            end else if (w_a_head == TERM) begin
                w_pop_b = 1'b1;
                w_nxt   = w_b_head;
            end else if (w_b_head == TERM) begin
                w_pop_a = 1'b1;
            end else if (DESCEND ? (w_a_head >= w_b_head) : (w_a_head <= w_b_head)) begin
                w_pop_a = 1'b1;
            end else begin
                w_pop_b = 1'b1;
                w_nxt   = w_b_head;
            end
        end
    end

    // Output register; holds its word until downstream takes it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_or        <= '0;
            r_ov        <= 1'b0;
            r_run_count <= '0;
        end else begin
            if (w_adv) begin
                r_or <= w_nxt;
                r_ov <= 1'b1;
            end else if (i_fifo_out_ready) begin
                r_ov <= 1'b0;
            end
            if (w_run_done) r_run_count <= r_run_count + 16'd1;
        end
    end

    assign o_data           = r_or;
    assign o_out_fifo_write = r_ov & i_fifo_out_ready;
    assign o_run_count      = r_run_count;
    assign o_busy           = ~w_a_empty | ~w_b_empty | r_ov;
endmodule

// File: tb/tb_stream_merger_p.sv
// Bench for stream_merger_p: three instances (ascending/DEPTH=4,
// descending/DEPTH=4, ascending/DEPTH=2) fed from array-backed FWFT sources.
module tb_stream_merger_p;
    localparam int N    = 3;
    localparam int MAXW = 80;
    typedef logic [31:0] w_t;

    // Byte lanes: a[0] is the first word of the run.
    typedef struct packed {
        logic [1:0]      k;
        logic [3:0]      n1;
        logic [3:0]      n2;
        logic [3:0]      ne;
        logic [7:0][7:0] a;
        logic [7:0][7:0] b;
        logic [7:0][7:0] e;
        logic [15:0]     rc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0][31:0] f1, f2, dout;
    logic [N-1:0][15:0] rc;
    logic [N-1:0]       e1, e2, rd1, rd2, wr, busy;
    logic [N-1:0]       rdy   = '1;
    logic [N-1:0]       hold2 = '0;

    int n1 [N];
    int n2 [N];
    int p1 [N];
    int p2 [N];
    int ng [N];
    int r1cyc [N];
    w_t src1 [N][MAXW];
    w_t src2 [N][MAXW];
    w_t got  [N][MAXW];
    int wcyc [N][MAXW];
    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    vec_t tbl [6];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DEP = (g == 2) ? 2 : 4;
        localparam bit DSC = (g == 1);
        stream_merger_p #(.W(32), .DEPTH(DEP), .DESCEND(DSC), .TERM(32'd0)) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_fifo_1(f1[g]), .i_fifo_1_empty(e1[g]), .o_fifo_1_read(rd1[g]),
            .i_fifo_2(f2[g]), .i_fifo_2_empty(e2[g]), .o_fifo_2_read(rd2[g]),
            .i_fifo_out_ready(rdy[g]), .o_out_fifo_write(wr[g]),
            .o_data(dout[g]), .o_run_count(rc[g]), .o_busy(busy[g])
        );
    end

    // Upstream FWFT heads
    always_comb begin
        for (int k = 0; k < N; k++) begin
            f1[k] = (p1[k] < MAXW) ? src1[k][p1[k]] : 32'd0;
            f2[k] = (p2[k] < MAXW) ? src2[k][p2[k]] : 32'd0;
            e1[k] = (p1[k] >= n1[k]);
            e2[k] = (p2[k] >= n2[k]) || hold2[k];
        end
    end

    // Upstream pops and downstream capture
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                p1[k] <= 0;
                p2[k] <= 0;
                ng[k] <= 0;
            end else begin
                if (rd1[k]) begin
                    if (p1[k] == 0) r1cyc[k] <= cyc;
                    p1[k] <= p1[k] + 1;
                end
                if (rd2[k]) p2[k] <= p2[k] + 1;
                if (wr[k] && ng[k] < MAXW) begin
                    got[k][ng[k]]  <= dout[k];
                    wcyc[k][ng[k]] <= cyc;
                end
                if (wr[k]) ng[k] <= ng[k] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            n1[k] = 0; n2[k] = 0; hold2[k] = 1'b0; rdy[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_out(input int k, input int n, input int budget);
        int t;
        t = 0;
        while (ng[k] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("out_count_timeout", ng[k], n);
        repeat (4) @(negedge clk);
        chk("out_count_final", ng[k], n);
        chk("idle_busy", {31'd0, busy[k]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   k;
        int   t;
        logic stall;
        w_t   prev;

        tbl[0] = '{k:2'd0, n1:4'd4, n2:4'd4, ne:4'd7, a:64'h00000000_00070401,
                   b:64'h00000000_00090302, e:64'h00000907_04030201, rc:16'd1};
        tbl[1] = '{k:2'd1, n1:4'd4, n2:4'd3, ne:4'd6, a:64'h00000000_00050509,
                   b:64'h00000000_00000205, e:64'h00000002_05050509, rc:16'd1};
        tbl[2] = '{k:2'd2, n1:4'd3, n2:4'd1, ne:4'd3, a:64'h00000000_00000803,
                   b:64'h0, e:64'h00000000_00000803, rc:16'd1};
        tbl[3] = '{k:2'd0, n1:4'd1, n2:4'd3, ne:4'd3, a:64'h0,
                   b:64'h00000000_00000606, e:64'h00000000_00000606, rc:16'd1};
        tbl[4] = '{k:2'd1, n1:4'd2, n2:4'd2, ne:4'd3, a:64'h00000000_00000007,
                   b:64'h00000000_00000007, e:64'h00000000_00000707, rc:16'd1};
        tbl[5] = '{k:2'd2, n1:4'd3, n2:4'd2, ne:4'd4, a:64'h00000000_0000C864,
                   b:64'h00000000_00000096, e:64'h00000000_00C89664, rc:16'd1};

        // Table-driven single-run merges
        for (int i = 0; i < 6; i++) begin
            k = int'(tbl[i].k);
            do_reset();
            for (int j = 0; j < 8; j++) begin
                src1[k][j] = {24'd0, tbl[i].a[j]};
                src2[k][j] = {24'd0, tbl[i].b[j]};
            end
            n1[k] = int'(tbl[i].n1);
            n2[k] = int'(tbl[i].n2);
            @(negedge clk);
            chk($sformatf("v%0d_rst_read1", i), {31'd0, rd1[k]}, 32'd0);
            chk($sformatf("v%0d_rst_read2", i), {31'd0, rd2[k]}, 32'd0);
            chk($sformatf("v%0d_rst_write", i), {31'd0, wr[k]}, 32'd0);
            chk($sformatf("v%0d_rst_busy", i), {31'd0, busy[k]}, 32'd0);
            chk($sformatf("v%0d_rst_data", i), dout[k], 32'd0);
            chk($sformatf("v%0d_rst_rc", i), {16'd0, rc[k]}, 32'd0);
            rst = 1'b0;
            wait_out(k, int'(tbl[i].ne), 60);
            for (int j = 0; j < int'(tbl[i].ne); j++)
                chk($sformatf("v%0d_w%0d", i, j), got[k][j], {24'd0, tbl[i].e[j]});
            chk($sformatf("v%0d_rc", i), {16'd0, rc[k]}, {16'd0, tbl[i].rc});
            if (i == 0) chk("latency", wcyc[0][0] - r1cyc[0], 32'd2);
        end

        // Backpressure on the DEPTH=2 instance: ready pattern 1,0,0,1
        do_reset();
        for (int j = 0; j < 8; j++) begin
            src1[2][j] = 2 * j + 1;
            src2[2][j] = 2 * j + 2;
        end
        src1[2][8] = 0; src2[2][8] = 0;
        n1[2] = 9; n2[2] = 9;
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (ng[2] < 17 && t < 300) begin
            rdy[2] = (t % 4 == 0) || (t % 4 == 3);
            stall  = g_dut[2].u_dut.r_ov & ~rdy[2];
            prev   = dout[2];
            @(negedge clk);
            if (stall) chk("bp_hold", dout[2], prev);
            t++;
        end
        rdy[2] = 1'b1;
        wait_out(2, 17, 20);
        for (int j = 0; j < 16; j++) chk($sformatf("bp_w%0d", j), got[2][j], j + 1);
        chk("bp_term", got[2][16], 32'd0);
        chk("bp_rc", {16'd0, rc[2]}, 32'd1);

        // Three back-to-back runs at full rate through DEPTH=4 (pointer wrap)
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                src1[0][r * 11 + i] = r * 100 + 2 * i + 1;
                src2[0][r * 11 + i] = r * 100 + 2 * i + 2;
            end
            src1[0][r * 11 + 10] = 0;
            src2[0][r * 11 + 10] = 0;
        end
        n1[0] = 33; n2[0] = 33;
        @(negedge clk);
        rst = 1'b0;
        wait_out(0, 63, 200);
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 20; j++)
                chk($sformatf("wrap_r%0d_w%0d", r, j), got[0][r * 21 + j], r * 100 + j + 1);
            chk($sformatf("wrap_r%0d_term", r), got[0][r * 21 + 20], 32'd0);
        end
        for (int j = 1; j < 63; j++)
            chk($sformatf("rate_gap%0d", j), wcyc[0][j] - wcyc[0][j - 1], 32'd1);
        chk("wrap_rc", {16'd0, rc[0]}, 32'd3);

        // One channel empty: the merge must not proceed
        do_reset();
        src1[0][0] = 5; src1[0][1] = 0;
        src2[0][0] = 6; src2[0][1] = 0;
        n1[0] = 2; n2[0] = 2;
        hold2[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("stall_nowrite%0d", c), {31'd0, wr[0]}, 32'd0);
        end
        hold2[0] = 1'b0;
        wait_out(0, 3, 30);
        chk("stall_w0", got[0][0], 32'd5);
        chk("stall_w1", got[0][1], 32'd6);
        chk("stall_w2", got[0][2], 32'd0);
        chk("stall_rc", {16'd0, rc[0]}, 32'd1);

        // Asynchronous reset in the middle of the second run
        do_reset();
        src1[0][0] = 1; src1[0][1] = 0; src1[0][2] = 3; src1[0][3] = 5; src1[0][4] = 7; src1[0][5] = 0;
        src2[0][0] = 2; src2[0][1] = 0; src2[0][2] = 4; src2[0][3] = 6; src2[0][4] = 8; src2[0][5] = 0;
        n1[0] = 6; n2[0] = 6;
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (ng[0] < 4 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("ar_pre_count", (ng[0] >= 4) ? 32'd1 : 32'd0, 32'd1);
        chk("ar_pre_w0", got[0][0], 32'd1);
        chk("ar_pre_w2", got[0][2], 32'd0);
        chk("ar_pre_w3", got[0][3], 32'd3);
        chk("ar_pre_rc", {16'd0, rc[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_write", {31'd0, wr[0]}, 32'd0);
        chk("ar_data", dout[0], 32'd0);
        chk("ar_rc", {16'd0, rc[0]}, 32'd0);
        chk("ar_busy", {31'd0, busy[0]}, 32'd0);
        chk("ar_read1", {31'd0, rd1[0]}, 32'd0);
        chk("ar_read2", {31'd0, rd2[0]}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("ar_hold_write", {31'd0, wr[0]}, 32'd0);
        end
        do_reset();
        src1[0][0] = 2; src1[0][1] = 0;
        src2[0][0] = 1; src2[0][1] = 0;
        n1[0] = 2; n2[0] = 2;
        @(negedge clk);
        rst = 1'b0;
        wait_out(0, 3, 30);
        chk("ar_post_w0", got[0][0], 32'd1);
        chk("ar_post_w1", got[0][1], 32'd2);
        chk("ar_post_w2", got[0][2], 32'd0);
        chk("ar_post_rc", {16'd0, rc[0]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
